// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one imem request in flight and
// buffers the returned word for decode. Redirects squash any stale fetch.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        next_addr_en,
  input  logic [31:0] next_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DROP, HOLD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] fetch_pc;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;
  logic [31:0] redirect;

  assign redirect = next_addr & ~32'h3;

  // DROP waits out a response whose request was made stale by a redirect.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      fetch_pc  <= 32'h0;
      inst_q    <= 32'h0;
      inst_pc_q <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          state <= REQ;
          if (next_addr_en) pc <= redirect;
        end
        REQ: begin
          if (imem_gnt) begin
            if (next_addr_en) begin
              pc    <= redirect;
              state <= DROP;
            end else begin
              fetch_pc <= pc;
              pc       <= pc + 32'd4;
              state    <= WAIT;
            end
          end else if (next_addr_en) begin
            pc <= redirect;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (next_addr_en) begin
              pc    <= redirect;
              state <= REQ;
            end else begin
              inst_q    <= imem_rdata;
              inst_pc_q <= fetch_pc;
              state     <= HOLD;
            end
          end else if (next_addr_en) begin
            pc    <= redirect;
            state <= DROP;
          end
        end
        DROP: begin
          if (imem_rvalid) state <= REQ;
          if (next_addr_en) pc <= redirect;
        end
        HOLD: begin
          if (next_addr_en) begin
            pc    <= redirect;
            state <= REQ;
          end else if (inst_ready) begin
            state <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign imem_req   = (state == REQ);
  assign imem_addr  = pc;
  assign inst_valid = (state == HOLD);
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed test-plan scenarios followed by randomized
// traffic, all checked against a transaction-level model of the fetch stage.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        nrst;
  logic        next_addr_en;
  logic [31:0] next_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  logic        imem_req2;
  logic [31:0] imem_addr2;
  logic        inst_valid2;
  logic [31:0] inst2;
  logic [31:0] inst_pc2;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit dut (
    .clk(clk), .nrst(nrst),
    .next_addr_en(next_addr_en), .next_addr(next_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ready(inst_ready)
  );

  // Always-granting memory that answers every cycle; decode never accepts.
  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .nrst(nrst),
    .next_addr_en(1'b0), .next_addr(32'h0),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_gnt(1'b1),
    .imem_rvalid(1'b1), .imem_rdata(32'hCAFE_0013),
    .inst_valid(inst_valid2), .inst(inst2), .inst_pc(inst_pc2),
    .inst_ready(1'b0)
  );

  always #5 clk = ~clk;

  // Model: fetch progress as flags (started, request outstanding, outstanding
  // one is stale, instruction buffered) rather than a state machine.
  logic        m_started, m_out, m_stale, m_buf;
  logic [31:0] m_pc, m_fetch_pc, m_inst, m_inst_pc;

  function automatic logic m_req();
    return m_started && !m_out && !m_buf;
  endfunction

  task automatic model_reset();
    m_started = 0; m_out = 0; m_stale = 0; m_buf = 0;
    m_pc = 32'h0; m_fetch_pc = 32'h0; m_inst = 32'h0; m_inst_pc = 32'h0;
  endtask

  task automatic model_update(input logic en, input logic [31:0] tgt,
                              input logic g, input logic rv,
                              input logic [31:0] rd, input logic rdy);
    logic [31:0] target;
    target = {tgt[31:2], 2'b00};
    if (!m_started) begin
      m_started = 1;
      if (en) m_pc = target;
    end else if (m_req()) begin
      if (g) begin
        m_out   = 1;
        m_stale = en;
        if (!en) m_fetch_pc = m_pc;
        m_pc = en ? target : m_pc + 32'd4;
      end else if (en) begin
        m_pc = target;
      end
    end else if (m_out && !m_stale) begin
      if (rv) begin
        m_out = 0;
        if (en) m_pc = target;
        else begin
          m_buf = 1; m_inst = rd; m_inst_pc = m_fetch_pc;
        end
      end else if (en) begin
        m_pc = target; m_stale = 1;
      end
    end else if (m_out) begin
      if (rv) m_out = 0;
      if (en) m_pc = target;
    end else if (m_buf) begin
      if (en) begin
        m_pc = target; m_buf = 0;
      end else if (rdy) begin
        m_buf = 0;
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (nrst === 1'b1) begin
      checkOutput("imem_req", {31'h0, imem_req}, {31'h0, m_req()});
      checkOutput("imem_addr", imem_addr, m_pc);
      checkOutput("inst_valid", {31'h0, inst_valid}, {31'h0, m_buf});
      checkOutput("inst", inst, m_inst);
      checkOutput("inst_pc", inst_pc, m_inst_pc);
    end
  end

  task automatic applyStimulus(input logic en, input logic [31:0] tgt,
                               input logic g, input logic rv,
                               input logic [31:0] rd, input logic rdy);
    next_addr_en = en; next_addr = tgt; imem_gnt = g;
    imem_rvalid = rv; imem_rdata = rd; inst_ready = rdy;
    @(posedge clk);
    model_update(en, tgt, g, rv, rd, rdy);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_req"}, {31'h0, imem_req}, 32'h0);
    checkOutput({tag, "_addr"}, imem_addr, 32'h0);
    checkOutput({tag, "_valid"}, {31'h0, inst_valid}, 32'h0);
    checkOutput({tag, "_inst"}, inst, 32'h0);
    checkOutput({tag, "_pc"}, inst_pc, 32'h0);
  endtask

  logic        mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;

  initial begin
    logic        en, g, rv, rdy, req_before;
    logic [31:0] tgt, rd, pc_before;

    model_reset();
    nrst = 0;
    next_addr_en = 0; next_addr = 0; imem_gnt = 0;
    imem_rvalid = 0; imem_rdata = 0; inst_ready = 0;
    mem_busy = 0; mem_cnt = 0; mem_addr = 0;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    checkOutput("rst_addr2", imem_addr2, 32'hFFFF_FFFC);
    nrst = 1;

    // First fetch after reset, with the wrapping-PC instance alongside.
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t1_req", {31'h0, imem_req}, 32'h1);
    checkOutput("t1_addr", imem_addr, 32'h0);
    checkOutput("w_req2", {31'h0, imem_req2}, 32'h1);
    checkOutput("w_addr2", imem_addr2, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("w_addr2_wrap", imem_addr2, 32'h0);
    applyStimulus(0, 0, 0, 1, 32'h0000_0013, 0);
    checkOutput("t1_valid", {31'h0, inst_valid}, 32'h1);
    checkOutput("t1_inst", inst, 32'h0000_0013);
    checkOutput("t1_pc", inst_pc, 32'h0);
    checkOutput("w_valid2", {31'h0, inst_valid2}, 32'h1);
    checkOutput("w_inst2", inst2, 32'hCAFE_0013);
    checkOutput("w_pc2", inst_pc2, 32'hFFFF_FFFC);

    // Decode stalls for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 1, 0, 32'hBAD0_0000, 0);
      checkOutput("t2_inst", inst, 32'h0000_0013);
      checkOutput("t2_pc", inst_pc, 32'h0);
      checkOutput("t2_req", {31'h0, imem_req}, 32'h0);
    end
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("t2_next_addr", imem_addr, 32'h4);

    // Redirect while waiting without rvalid.
    applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(1, 32'h100, 0, 0, 0, 0);
    checkOutput("t3_valid_a", {31'h0, inst_valid}, 32'h0);
    applyStimulus(0, 0, 0, 1, 32'hDEAD_BEEF, 0);
    checkOutput("t3_valid_b", {31'h0, inst_valid}, 32'h0);
    checkOutput("t3_addr", imem_addr, 32'h100);
    applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 32'h0000_ABCD, 0);
    checkOutput("t3_inst", inst, 32'h0000_ABCD);
    checkOutput("t3_pc", inst_pc, 32'h100);

    // Redirect coincident with rvalid.
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(1, 32'h203, 0, 1, 32'h1111_1111, 0);
    checkOutput("t4_addr", imem_addr, 32'h200);
    checkOutput("t4_valid", {31'h0, inst_valid}, 32'h0);

    // Redirect in HOLD beats inst_ready.
    applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 32'h55, 0);
    applyStimulus(1, 32'h40, 0, 0, 0, 1);
    checkOutput("t5_valid", {31'h0, inst_valid}, 32'h0);
    checkOutput("t5_addr", imem_addr, 32'h40);

    // Top-of-memory fetch wraps to zero.
    applyStimulus(1, 32'hFFFF_FFFF, 0, 0, 0, 0);
    checkOutput("t6_addr", imem_addr, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("t6_wrap", imem_addr, 32'h0);
    applyStimulus(0, 0, 0, 1, 32'h77, 0);
    checkOutput("t6_pc", inst_pc, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 0, 0, 0, 1);

    // Random traffic against a single-slot memory with 1..3 cycle latency.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 249) == 0) begin
        #1 nrst = 0;
        #1 check_reset_outputs("async_rst");
        model_reset();
        @(negedge clk);
        nrst = 1;
        continue;
      end
      en  = ($urandom_range(0, 7) == 0);
      tgt = $urandom;
      g   = ($urandom_range(0, 2) != 0) && !mem_busy;
      rv  = mem_busy && (mem_cnt == 1);
      rd  = rv ? ({mem_addr[15:0], mem_addr[31:16]} ^ 32'h1357_9BDF) : $urandom;
      rdy = $urandom_range(0, 1) == 1;
      req_before = m_req();
      pc_before  = m_pc;
      applyStimulus(en, tgt, g, rv, rd, rdy);
      if (rv) mem_busy = 0;
      else if (mem_busy) mem_cnt--;
      if (req_before && g) begin
        mem_busy = 1;
        mem_cnt  = $urandom_range(1, 3);
        mem_addr = pc_before;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
